// File: rtl/minimig_ctrl_regs_spi_if.sv
`default_nettype none
// ============================================================================
// Module   : minimig_ctrl_regs_spi_if
// Brief    : Control-CPU 32-bit bus bundle for minimig_ctrl_regs_spi.
// Revision : 1.0
// ============================================================================
interface minimig_ctrl_regs_spi_if;
  logic        cs;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cs, we, adr, sel, dat_w, input dat_r, ack);
  modport slave  (input cs, we, adr, sel, dat_w, output dat_r, ack);
endinterface
`default_nettype wire

// File: rtl/minimig_ctrl_regs_spi.sv
`default_nettype none
// ============================================================================
// Module   : minimig_ctrl_regs_spi
// Brief    : Control-register bus slave with embedded byte-wide SPI master.
//            Optional free-running ms timer enabled by CTRL_REGS_TIMER_EN.
// Revision : 1.0
// ============================================================================
module minimig_ctrl_regs_spi #(
  parameter logic [31:0] ID_VALUE    = 32'h4d494e49,
  parameter logic [7:0]  SPI_DIV_RST = 8'd1,
  parameter logic [15:0] TIMER_DIV   = 16'd50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  minimig_ctrl_regs_spi_if.slave   bus,
  output logic [7:0]               ctrl_out,
  output logic [3:0]               spi_cs_n,
  output logic                     spi_sck,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER     = 2'd1,
    ST_FINISH   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_r_q, dat_r_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  csr_q, csr_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rxsh_q, rxsh_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [2:0]  falls_q, falls_d;

  logic [31:0] w_timer;
  logic [31:0] w_rdata;
  logic        w_wr_lane0;
  logic        w_spi_start;
  logic        unused_bits;

  assign unused_bits = ^{bus.adr[31:5], bus.adr[1:0], bus.dat_w[31:8], bus.sel[3:1]};

`ifdef CTRL_REGS_TIMER_EN
  logic [31:0] timer_q;
  logic [15:0] tdiv_q;
  logic        w_timer_clr;

  assign w_timer_clr = (state_q == ST_IDLE) && bus.cs && bus.we && (bus.adr[4:2] == 3'd2);
  assign w_timer     = timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      tdiv_q  <= '0;
    end else if (w_timer_clr) begin
      timer_q <= '0;
      tdiv_q  <= '0;
    end else if (tdiv_q == TIMER_DIV - 16'd1) begin
      timer_q <= timer_q + 32'd1;
      tdiv_q  <= '0;
    end else begin
      tdiv_q  <= tdiv_q + 16'd1;
    end
  end
`else
  logic unused_timer_div;
  assign unused_timer_div = ^TIMER_DIV;
  assign w_timer          = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.adr[4:2])
      3'd0:    w_rdata = ID_VALUE;
      3'd1:    w_rdata = {24'h0, ctrl_q};
      3'd2:    w_rdata = w_timer;
      3'd4:    w_rdata = {24'h0, div_q};
      3'd5:    w_rdata = {25'h0, csr_q};
      3'd6:    w_rdata = {24'h0, rx_q};
      default: w_rdata = '0;
    endcase
  end

  assign w_wr_lane0  = bus.cs && bus.we && bus.sel[0];
  // A data write with the enable clear completes like any plain register access.
  assign w_spi_start = w_wr_lane0 && (bus.adr[4:2] == 3'd6) && csr_q[6];

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_r_d = '0;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    csr_d   = csr_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rxsh_d  = rxsh_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    hcnt_d  = hcnt_q;
    falls_d = falls_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cs) begin
          if (w_wr_lane0) begin
            case (bus.adr[4:2])
              3'd1:    ctrl_d = bus.dat_w[7:0];
              3'd4:    div_d  = bus.dat_w[7:0];
              3'd5:    csr_d  = bus.dat_w[6:0];
              default: ;
            endcase
          end
          if (w_spi_start) begin
            mosi_d  = bus.dat_w[7];
            tx_d    = {bus.dat_w[6:0], 1'b1};
            hcnt_d  = '0;
            falls_d = '0;
            state_d = ST_XFER;
          end else begin
            ack_d   = 1'b1;
            dat_r_d = bus.we ? 32'h0 : w_rdata;
            state_d = ST_WAIT_LOW;
          end
        end
      end

      ST_XFER: begin
        if (hcnt_q == div_q) begin
          hcnt_d = '0;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            rxsh_d = {rxsh_q[6:0], spi_miso};
          end else begin
            // Shift in ones so mosi rests high once the byte is out.
            mosi_d  = tx_q[7];
            tx_d    = {tx_q[6:0], 1'b1};
            falls_d = falls_q + 3'd1;
            if (falls_q == 3'd7) begin
              rx_d    = rxsh_q;
              state_d = ST_FINISH;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      ST_FINISH: begin
        ack_d   = 1'b1;
        state_d = ST_WAIT_LOW;
      end

      ST_WAIT_LOW: begin
        if (!bus.cs) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_r_q <= '0;
      ctrl_q  <= '0;
      div_q   <= SPI_DIV_RST;
      csr_q   <= '0;
      rx_q    <= '0;
      tx_q    <= 8'hff;
      rxsh_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      hcnt_q  <= '0;
      falls_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_r_q <= dat_r_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      csr_q   <= csr_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      hcnt_q  <= hcnt_d;
      falls_q <= falls_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.dat_r = dat_r_q;
  assign ctrl_out  = ctrl_q;
  assign spi_cs_n  = ~csr_q[3:0];
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_minimig_ctrl_regs_spi.sv
`default_nettype none
// ============================================================================
// Module   : tb_minimig_ctrl_regs_spi
// Brief    : Scoreboard bench for minimig_ctrl_regs_spi (timer part under
//            CTRL_REGS_TIMER_EN).
// Revision : 1.0
// ============================================================================
module tb_minimig_ctrl_regs_spi;

  localparam logic [31:0] BASE = 32'h0080_0000;
  localparam logic [31:0] ID   = 32'h4d494e49;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ctrl_out;
  logic [3:0] spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso = 1'b1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  minimig_ctrl_regs_spi_if bus_if();

  minimig_ctrl_regs_spi #(
    .ID_VALUE    (ID),
    .SPI_DIV_RST (8'd1),
    .TIMER_DIV   (16'd4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .ctrl_out (ctrl_out),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  // Drives one bus cycle, acts as an SPI slave returning miso_byte, and
  // reports read data, latency, captured mosi byte, SCK pulses and ack after.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [7:0] miso_byte,
                        output logic [31:0] rd, output int lat,
                        output logic [7:0] mosi_byte, output int pulses,
                        output logic ack_after);
    int   bitn;
    logic prev;
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.we = w; bus_if.adr = a; bus_if.sel = s; bus_if.dat_w = d;
    lat = 0; pulses = 0; bitn = 0; mosi_byte = '0; rd = 'x;
    prev = spi_sck;
    spi_miso = miso_byte[7];
    while (lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (spi_sck && !prev) begin
        mosi_byte = {mosi_byte[6:0], spi_mosi};
        pulses++;
        bitn++;
      end
      if (!spi_sck && prev && bitn < 8) spi_miso = miso_byte[7-bitn];
      prev = spi_sck;
      if (bus_if.ack) begin
        rd = bus_if.dat_r;
        break;
      end
    end
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    @(posedge clk); #1;
    ack_after = bus_if.ack;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.adr = '0; bus_if.sel = '0; bus_if.dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (spi_cs_n !== 4'hf || spi_sck !== 1'b0 || spi_mosi !== 1'b1 || ctrl_out !== 8'h0 ||
        bus_if.ack !== 1'b0 || bus_if.dat_r !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cs_n=%h sck=%b mosi=%b ctrl=%h ack=%b dat_r=%h want f 0 1 00 0 0",
               spi_cs_n, spi_sck, spi_mosi, ctrl_out, bus_if.ack, bus_if.dat_r);
    end
    rst_n = 1'b1;
    exp_q.push_back('{ID, 1});
    access(1'b0, BASE, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || lat !== e.lat) begin
      n_fail++; $display("FAIL id_read: got %h lat %0d want %h lat %0d", rd, lat, e.data, e.lat);
    end
    n_cmp++;
    if (aa !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: ack still %b want 0", aa); end
    exp_q.push_back('{32'h1, 1});
    access(1'b0, BASE + 32'h10, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin n_fail++; $display("FAIL div_reset: got %h want %h", rd, e.data); end
  endtask

  task automatic test_cs_reg();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    exp_q.push_back('{32'h0, 1});
    access(1'b1, BASE + 32'h14, 4'hf, 32'h44, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== e.lat || spi_cs_n !== 4'b1011) begin
      n_fail++; $display("FAIL cs_write: lat %0d cs_n %b want lat %0d cs_n 1011", lat, spi_cs_n, e.lat);
    end
    exp_q.push_back('{32'h44, 1});
    access(1'b0, BASE + 32'h14, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin n_fail++; $display("FAIL cs_readback: got %h want %h", rd, e.data); end
    access(1'b1, BASE + 32'h14, 4'hf, 32'h40, 8'hff, rd, lat, mb, p, aa);
    n_cmp++;
    if (spi_cs_n !== 4'hf) begin n_fail++; $display("FAIL cs_deselect: got %b want 1111", spi_cs_n); end
    access(1'b1, BASE + 32'h14, 4'hf, 32'h44, 8'hff, rd, lat, mb, p, aa);
  endtask

  task automatic test_ctrl_sel();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    access(1'b1, BASE + 32'h04, 4'b0001, 32'h12345603, 8'hff, rd, lat, mb, p, aa);
    n_cmp++;
    if (ctrl_out !== 8'h03) begin n_fail++; $display("FAIL ctrl_lane0: got %h want 03", ctrl_out); end
    access(1'b1, BASE + 32'h04, 4'b1110, 32'hffffffff, 8'hff, rd, lat, mb, p, aa);
    n_cmp++;
    if (ctrl_out !== 8'h03) begin n_fail++; $display("FAIL ctrl_upper_lanes: got %h want 03", ctrl_out); end
    exp_q.push_back('{32'h3, 1});
    access(1'b0, BASE + 32'h04, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin n_fail++; $display("FAIL ctrl_readback: got %h want %h", rd, e.data); end
  endtask

  task automatic test_reserved();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    logic [31:0] offs [3] = '{32'h0c, 32'h1c, 32'h08};
    for (int i = 0; i < 3; i++) begin
`ifdef CTRL_REGS_TIMER_EN
      if (i == 2) break;
`endif
      access(1'b1, BASE + offs[i], 4'hf, 32'hffffffff, 8'hff, rd, lat, mb, p, aa);
      exp_q.push_back('{32'h0, 1});
      access(1'b0, BASE + offs[i], 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.data || lat !== e.lat) begin
        n_fail++; $display("FAIL reserved_%h: got %h lat %0d want %h lat %0d", offs[i], rd, lat, e.data, e.lat);
      end
    end
  endtask

  task automatic test_spi();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    logic [7:0] tx [11] = '{8'h1c, 8'h00, 8'h00, 8'h18, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    logic [7:0] rxb;
    for (int i = 0; i < 11; i++) begin
      rxb = (tx[i] == 8'h00) ? 8'ha5 : (tx[i] ^ 8'h3c);
      exp_q.push_back('{{24'h0, tx[i]}, 34});
      access(1'b1, BASE + 32'h18, 4'hf, {24'hdead00, tx[i]}, rxb, rd, lat, mb, p, aa);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== e.lat || {24'h0, mb} !== e.data || p !== 8) begin
        n_fail++; $display("FAIL spi_tx_%0d: lat %0d mosi %h pulses %0d want lat %0d mosi %h pulses 8",
                           i, lat, mb, p, e.lat, e.data[7:0]);
      end
      exp_q.push_back('{{24'h0, rxb}, 1});
      access(1'b0, BASE + 32'h18, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.data) begin n_fail++; $display("FAIL spi_rx_%0d: got %h want %h", i, rd, e.data); end
    end
  endtask

  task automatic test_spi_div();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    logic [7:0] divs [3] = '{8'd0, 8'd3, 8'd1};
    for (int i = 0; i < 3; i++) begin
      access(1'b1, BASE + 32'h10, 4'hf, {24'h0, divs[i]}, 8'hff, rd, lat, mb, p, aa);
      exp_q.push_back('{32'h96, 16 * (int'(divs[i]) + 1) + 2});
      access(1'b1, BASE + 32'h18, 4'hf, 32'h96, 8'h69, rd, lat, mb, p, aa);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== e.lat || mb !== e.data[7:0]) begin
        n_fail++; $display("FAIL spi_div_%0d: lat %0d mosi %h want lat %0d mosi %h", divs[i], lat, mb, e.lat, e.data[7:0]);
      end
    end
  endtask

  task automatic test_spi_disabled();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    access(1'b1, BASE + 32'h14, 4'hf, 32'h04, 8'hff, rd, lat, mb, p, aa);
    exp_q.push_back('{32'h0, 1});
    access(1'b1, BASE + 32'h18, 4'hf, 32'h5a, 8'h00, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== e.lat || p !== 0 || spi_cs_n !== 4'b1011) begin
      n_fail++; $display("FAIL spi_disabled: lat %0d pulses %0d cs_n %b want lat 1 pulses 0 cs_n 1011", lat, p, spi_cs_n);
    end
    exp_q.push_back('{32'h69, 1});
    access(1'b0, BASE + 32'h18, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin n_fail++; $display("FAIL spi_disabled_rx: got %h want %h", rd, e.data); end
    access(1'b1, BASE + 32'h14, 4'hf, 32'h44, 8'hff, rd, lat, mb, p, aa);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, p, acks; logic [7:0] mb; logic aa; exp_t e;
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.adr = BASE; bus_if.sel = 4'hf;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus_if.ack) acks++;
    end
    bus_if.cs = 1'b0;
    n_cmp++;
    if (acks !== 1) begin n_fail++; $display("FAIL held_cs_acks: got %0d want 1", acks); end
    exp_q.push_back('{32'h44, 1});
    access(1'b0, BASE + 32'h14, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || lat !== e.lat) begin
      n_fail++; $display("FAIL b2b_next: got %h lat %0d want %h lat %0d", rd, lat, e.data, e.lat);
    end
  endtask

`ifdef CTRL_REGS_TIMER_EN
  task automatic test_timer();
    logic [31:0] rd, t0; int lat, p; logic [7:0] mb; logic aa;
    access(1'b1, BASE + 32'h08, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    repeat (20) @(posedge clk);
    access(1'b0, BASE + 32'h08, 4'hf, 32'h0, 8'hff, t0, lat, mb, p, aa);
    repeat (37) @(posedge clk);
    exp_q.push_back('{t0 + 32'd10, 1});
    access(1'b0, BASE + 32'h08, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    n_cmp++;
    if (rd !== exp_q[0].data) begin n_fail++; $display("FAIL timer_delta: got %h want %h", rd, exp_q[0].data); end
    void'(exp_q.pop_front());
  endtask
`endif

  task automatic test_reset_midxfer();
    logic [31:0] rd; int lat, p; logic [7:0] mb; logic aa; exp_t e;
    logic seen;
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.adr = BASE + 32'h18; bus_if.sel = 4'hf; bus_if.dat_w = 32'h3c;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (spi_sck) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL midxfer_active: sck seen %b want 1", seen); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (spi_sck !== 1'b0 || spi_cs_n !== 4'hf || spi_mosi !== 1'b1 || bus_if.ack !== 1'b0) begin
      n_fail++; $display("FAIL midxfer_reset: sck %b cs_n %b mosi %b ack %b want 0 1111 1 0",
                         spi_sck, spi_cs_n, spi_mosi, bus_if.ack);
    end
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back('{ID, 1});
    access(1'b0, BASE, 4'hf, 32'h0, 8'hff, rd, lat, mb, p, aa);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || lat !== e.lat) begin
      n_fail++; $display("FAIL post_reset_id: got %h lat %0d want %h lat %0d", rd, lat, e.data, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_cs_reg();
    test_ctrl_sel();
    test_reserved();
    test_spi();
    test_spi_div();
    test_spi_disabled();
    test_back_to_back();
`ifdef CTRL_REGS_TIMER_EN
    test_timer();
`endif
    test_reset_midxfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minimig_ctrl_regs_spi.md
Name: minimig_ctrl_regs_spi

Overview:
- Memory-mapped control-register slave for the minimig control CPU, with an embedded byte-wide SPI master.
- The SPI master drives the OSD/user-IO, SD card and spare SPI chip selects.
- Sits between the control CPU's 32-bit bus and the SPI slaves in minimig_de1_top.
- The upper address decode (base 0x00800000) is done externally and arrives as cs.

Parameters:
- ID_VALUE, 32'h4d494e49, read-only value at offset 0x00.
- SPI_DIV_RST, 8'd1, reset value of the SPI clock divider.
- TIMER_DIV, 16'd50000, clk cycles per timer tick (1 ms at 50 MHz); used only with the timer feature.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  bus cycle request; held high by the master until ack.
- we  in  1  1 = write, 0 = read.
- adr  in  32  byte address; only adr[4:2] is decoded.
- sel  in  4  byte enables for writes.
- dat_w  in  32  write data.
- dat_r  out  32  read data, valid in the cycle ack is high.
- ack  out  1  one-cycle completion pulse.
- ctrl_out  out  8  general control bits (bit0 = system reset request, bit1 = CPU halt).
- spi_cs_n  out  4  active-low chip selects; bit2 = OSD.
- spi_sck  out  1  SPI clock, mode 0, idle low.
- spi_mosi  out  1  SPI data out, MSB first.
- spi_miso  in  1  SPI data in.

Behaviour:
- Reset values: dat_r=0, ack=0, ctrl_out=0, spi_cs_n=4'hf, spi_sck=0, spi_mosi=1, divider=SPI_DIV_RST, rx byte=0, timer=0.
- Register map by adr[4:2], offsets from the base:
  - 0x00: ID, read-only.
  - 0x04: CTRL, read/write, bits[7:0] drive ctrl_out.
  - 0x08: TIMER, read-only.
  - 0x0C: reserved; reads 0, writes ignored.
  - 0x10: SPI_DIV, read/write, bits[7:0].
  - 0x14: SPI_CS, read/write, bits[6:0]. Bit6 = SPI_EN. Bits[3:0] = chip selects, active-high in the register; spi_cs_n = ~bits[3:0].
  - 0x18: SPI_DAT. A write starts a transfer; a read returns {24'h0, rx byte}.
  - 0x1C: reserved; reads 0, writes ignored.
- Write byte enables: only lanes with sel=1 update; all registers use lane 0 except ID and TIMER.
- Handshake:
  - Every access except a SPI_DAT write with SPI_EN=1 acks in the cycle after cs is first sampled high. Latency is 1.
  - ack is high for exactly one cycle.
  - A new access is accepted only after cs has been sampled low for at least one cycle following ack; cs held high after ack does not re-trigger.
- SPI transfer (SPI_DAT write, SPI_EN=1):
  - Latch dat_w[7:0] and shift 8 bits MSB first.
  - Each SCK half-period = SPI_DIV+1 clk cycles.
  - mosi is set up on the falling edge (first bit before the first rising edge); miso is sampled on the rising edge.
  - After the 8th falling edge SCK returns low, the rx byte updates, and ack pulses on the next clk. Total latency = 16*(SPI_DIV+1)+2 cycles.
- SPI_DAT write with SPI_EN=0: no SCK activity, ack after 1 cycle, rx byte unchanged.
- A CS register write during a transfer cannot occur, because the bus is blocked until ack.
- Asynchronous reset mid-transfer: abort immediately, all outputs go to their reset values.

Optional Feature:
- Macro CTRL_REGS_TIMER_EN.
- Defined: a 32-bit TIMER counts up once every TIMER_DIV clk cycles, wraps from 0xFFFFFFFF to 0, and is cleared by a write of any value to 0x08.
- Undefined: no counter logic; 0x08 reads 0 and writes are ignored.

Test Plan:
- Reset: after rst_n release, read 0x00800000 -> dat_r=0x4d494e49 with ack 1 cycle after cs; spi_cs_n=4'hf, spi_sck=0.
- Write 0x00800014=0x44 -> ack in 1 cycle, spi_cs_n=4'b1011; read back -> 0x44. Write 0x40 -> spi_cs_n=4'hf.
- With CS=0x44 and divider=1, write 0x00800018 with 0x1c, 0x00, 0x00, 0x18, 0x00, 0xaa..0xff -> each byte appears MSB first on mosi over 8 SCK pulses, ack 34 cycles after cs.
- Tie miso such that it returns 0xa5 during a 0x00 write -> a read of 0x00800018 returns 0x000000a5.
- Write 0x00800004=0x12345603 with sel=4'b0001 -> ctrl_out=0x03; then sel=4'b1110 -> ctrl_out unchanged.
- With CTRL_REGS_TIMER_EN and TIMER_DIV=4: reads of 0x08 taken 40 cycles apart differ by 10; assert rst_n low mid-transfer -> spi_sck=0 and spi_cs_n=4'hf immediately.
